// File: rtl/reset_request_ctrl_if.sv
// Handshake bundle between the reset-request source and its surroundings
// (button / watchdog inputs, reset request and status outputs).
interface reset_request_ctrl_if;
  logic       btn_in;
  logic       wdt_en;
  logic       wdt_kick;
  logic       rst_req_n;
  logic [1:0] rst_cause;
  logic       busy;

  modport master (output btn_in, wdt_en, wdt_kick, input rst_req_n, rst_cause, busy);
  modport slave  (input btn_in, wdt_en, wdt_kick, output rst_req_n, rst_cause, busy);
endinterface

// File: rtl/reset_request_ctrl.sv
// Reset request source: debounced button (and optional watchdog, enabled by defining
// RST_REQ_WATCHDOG_EN) stretched into a fixed-width active-low pulse with recorded cause.
module reset_request_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_CYCLES    = 8,
  parameter int WDT_CYCLES      = 1024
) (
  input  logic                 sys_clk,
  input  logic                 a_res_n,
  reset_request_ctrl_if.slave  bus
);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int PW_W = $clog2(PULSE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW_W-1:0] PW_LAST = PW_W'(PULSE_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_ASSERT, S_HOLDOFF} state_e;

  state_e          state_q, state_d;
  logic            btn_meta_q, btn_sync_q;
  logic [DB_W-1:0] db_q, db_d;
  logic [PW_W-1:0] pw_q, pw_d;
  logic [1:0]      cause_q, cause_d;
  logic            req_n_q, busy_q;
  logic            wdt_fire;

`ifdef RST_REQ_WATCHDOG_EN
  localparam int WD_W = $clog2(WDT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDT_CYCLES - 1);
  logic [WD_W-1:0] wdt_q, wdt_d;

  // Counter only runs while idle and enabled; a kick beats expiry in the same cycle.
  always_comb begin
    wdt_d    = '0;
    wdt_fire = 1'b0;
    if (state_q == S_IDLE && bus.wdt_en) begin
      if (bus.wdt_kick)          wdt_d = '0;
      else if (wdt_q == WD_LAST) wdt_fire = 1'b1;
      else                       wdt_d = wdt_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge a_res_n) begin
    if (!a_res_n) wdt_q <= '0;
    else          wdt_q <= wdt_d;
  end
`else
  logic unused_wdt;
  assign wdt_fire   = 1'b0;
  assign unused_wdt = bus.wdt_en ^ bus.wdt_kick;
`endif

  always_comb begin
    state_d = state_q;
    db_d    = db_q;
    pw_d    = pw_q;
    cause_d = cause_q;
    case (state_q)
      S_IDLE: begin
        // Watchdog expiry wins over a simultaneous button; HOLDOFF absorbs the button.
        if (wdt_fire) begin
          state_d = S_ASSERT;
          cause_d = 2'b10;
          pw_d    = '0;
        end else if (btn_sync_q) begin
          state_d = S_DEBOUNCE;
          db_d    = '0;
        end
      end
      S_DEBOUNCE: begin
        if (!btn_sync_q) state_d = S_IDLE;
        else if (db_q == DB_LAST) begin
          state_d = S_ASSERT;
          cause_d = 2'b01;
          pw_d    = '0;
        end else db_d = db_q + 1'b1;
      end
      S_ASSERT: begin
        if (pw_q == PW_LAST) state_d = S_HOLDOFF;
        else                 pw_d    = pw_q + 1'b1;
      end
      S_HOLDOFF: if (!btn_sync_q) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge a_res_n) begin
    if (!a_res_n) begin
      state_q    <= S_IDLE;
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
      db_q       <= '0;
      pw_q       <= '0;
      cause_q    <= 2'b00;
      req_n_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      btn_meta_q <= bus.btn_in;
      btn_sync_q <= btn_meta_q;
      db_q       <= db_d;
      pw_q       <= pw_d;
      cause_q    <= cause_d;
      req_n_q    <= (state_d != S_ASSERT);
      busy_q     <= (state_d != S_IDLE);
    end
  end

  assign bus.rst_req_n = req_n_q;
  assign bus.rst_cause = cause_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_reset_request_ctrl.sv
// Bench for reset_request_ctrl: hand-derived vector table, directed corner sequences,
// and randomized stimulus against a run-length reference model.
module tb_reset_request_ctrl;
  localparam int DB = 4;
  localparam int PW = 3;
  localparam int WD = 8;
`ifdef RST_REQ_WATCHDOG_EN
  localparam bit WDT_ON = 1'b1;
`else
  localparam bit WDT_ON = 1'b0;
`endif

  logic sys_clk = 1'b0;
  logic a_res_n = 1'b0;
  reset_request_ctrl_if dif();

  reset_request_ctrl #(.DEBOUNCE_CYCLES(DB), .PULSE_CYCLES(PW), .WDT_CYCLES(WD)) u_dut (
    .sys_clk (sys_clk),
    .a_res_n (a_res_n),
    .bus     (dif)
  );

  always #5 sys_clk = ~sys_clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: button samples through a 2-deep history, run lengths and
  // remaining-pulse counts instead of explicit states.
  bit       m_s0, m_s1;
  int       m_pulse, m_hold, m_run, m_idle;
  bit [1:0] m_cause;

  function automatic void model_reset();
    m_s0 = 0; m_s1 = 0; m_pulse = 0; m_hold = 0; m_run = 0; m_idle = 0; m_cause = 2'b00;
  endfunction

  function automatic void model_edge(bit btn, bit en, bit kick);
    bit bs, idle_now, fire;
    bs = m_s1; idle_now = 0; fire = 0;
    if (m_pulse > 0) begin
      m_pulse--;
      if (m_pulse == 0) m_hold = 1;
    end else if (m_hold != 0) begin
      if (!bs) m_hold = 0;
    end else if (m_run > 0) begin
      if (!bs) m_run = 0;
      else if (m_run == DB) begin m_run = 0; m_pulse = PW; m_cause = 2'b01; end
      else m_run++;
    end else begin
      idle_now = 1;
      if (WDT_ON && en) begin
        if (kick)                m_idle = 0;
        else if (m_idle == WD-1) begin fire = 1; m_idle = 0; end
        else                     m_idle++;
      end
      if (fire)    begin m_pulse = PW; m_cause = 2'b10; end
      else if (bs) m_run = 1;
    end
    if (!idle_now || !en) m_idle = 0;
    m_s1 = m_s0;
    m_s0 = btn;
  endfunction

  function automatic logic [3:0] model_out();
    return {(m_pulse == 0), m_cause, (m_pulse > 0 || m_hold != 0 || m_run > 0)};
  endfunction

  function automatic logic [3:0] dut_out();
    return {dif.rst_req_n, dif.rst_cause, dif.busy};
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got req_n/cause/busy=%b required %b", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    model_edge(dif.btn_in, dif.wdt_en, dif.wdt_kick);
    #1;
    chk("model", dut_out(), model_out());
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    a_res_n = 1'b0;
    model_reset();
    repeat (2) @(posedge sys_clk);
    #1;
    chk("reset_state", dut_out(), 4'b1_00_0);
    @(negedge sys_clk);
    a_res_n = 1'b1;
  endtask

  typedef struct {
    bit       btn;
    bit       req_n;
    bit [1:0] cause;
    bit       busy;
  } vec_t;
  vec_t tbl[23];

  initial begin
    int lows;
    int btn_left;
    dif.btn_in = 1'b0; dif.wdt_en = 1'b0; dif.wdt_kick = 1'b0;

    // Full press (held through pulse) then a 3-cycle glitch; one row per clock edge.
    tbl[0]  = '{1'b1, 1'b1, 2'd0, 1'b0}; tbl[1]  = '{1'b1, 1'b1, 2'd0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 2'd0, 1'b1}; tbl[3]  = '{1'b1, 1'b1, 2'd0, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 2'd0, 1'b1}; tbl[5]  = '{1'b1, 1'b1, 2'd0, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 2'd1, 1'b1}; tbl[7]  = '{1'b1, 1'b0, 2'd1, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 2'd1, 1'b1}; tbl[9]  = '{1'b1, 1'b1, 2'd1, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 2'd1, 1'b1}; tbl[11] = '{1'b1, 1'b1, 2'd1, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 2'd1, 1'b1}; tbl[13] = '{1'b0, 1'b1, 2'd1, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 2'd1, 1'b0}; tbl[15] = '{1'b0, 1'b1, 2'd1, 1'b0};
    tbl[16] = '{1'b1, 1'b1, 2'd1, 1'b0}; tbl[17] = '{1'b1, 1'b1, 2'd1, 1'b0};
    tbl[18] = '{1'b1, 1'b1, 2'd1, 1'b1}; tbl[19] = '{1'b0, 1'b1, 2'd1, 1'b1};
    tbl[20] = '{1'b0, 1'b1, 2'd1, 1'b1}; tbl[21] = '{1'b0, 1'b1, 2'd1, 1'b0};
    tbl[22] = '{1'b0, 1'b1, 2'd1, 1'b0};

    // Quiet after reset
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step();
      chk("quiet", dut_out(), 4'b1_00_0);
    end

    // Glitch from fresh reset leaves cause at 00
    do_reset();
    dif.btn_in = 1'b1;
    repeat (3) step();
    dif.btn_in = 1'b0;
    lows = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!dif.rst_req_n) lows++;
    end
    chk("glitch_idle", dut_out(), 4'b1_00_0);
    chk("glitch_no_pulse", {dif.rst_req_n, 3'(lows)}, 4'b1_000);

    // Vector table
    do_reset();
    for (int i = 0; i < 23; i++) begin
      dif.btn_in = tbl[i].btn;
      step();
      chk($sformatf("vec%0d", i), dut_out(), {tbl[i].req_n, tbl[i].cause, tbl[i].busy});
    end

    // Async reset during second low cycle of the pulse
    do_reset();
    dif.btn_in = 1'b1;
    lows = 0;
    for (int i = 0; i < 20 && dif.rst_req_n !== 1'b0; i++) step();
    chk("pulse_seen", {dif.rst_req_n, 3'd0}, 4'b0_000);
    step();
    #2 a_res_n = 1'b0;
    #1 chk("async_reset", dut_out(), 4'b1_00_0);
    dif.btn_in = 1'b0;
    model_reset();
    #2 a_res_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!dif.rst_req_n) lows++;
    end
    chk("no_resume", {dif.rst_cause, 2'(lows)}, 4'b00_00);

    if (WDT_ON) begin
      // Watchdog expiry with no kicks
      do_reset();
      dif.wdt_en = 1'b1;
      lows = 0;
      for (int i = 0; i < 12; i++) begin
        step();
        if (!dif.rst_req_n) lows++;
      end
      chk("wdt_pulse", {dif.rst_cause, 2'(lows)}, 4'b10_11);
      // Regular kicks keep it quiet
      do_reset();
      dif.wdt_en = 1'b1;
      lows = 0;
      for (int i = 0; i < 40; i++) begin
        dif.wdt_kick = (i % 5 == 4);
        step();
        if (!dif.rst_req_n) lows++;
      end
      dif.wdt_kick = 1'b0;
      chk("wdt_kicked", {dif.rst_cause, 2'(lows)}, 4'b00_00);
      // Expiry coincides with btn_sync rise: watchdog wins, HOLDOFF waits for release
      do_reset();
      dif.wdt_en = 1'b1;
      lows = 0;
      for (int i = 0; i < 20; i++) begin
        dif.btn_in = (i >= 5);
        step();
        if (!dif.rst_req_n) lows++;
      end
      dif.wdt_en = 1'b0;
      chk("wdt_vs_btn", {dif.rst_cause, 2'(lows)}, 4'b10_11);
      chk("holdoff_wait", dut_out(), 4'b1_10_1);
      dif.btn_in = 1'b0;
      repeat (4) step();
      chk("holdoff_exit", dut_out(), 4'b1_10_0);
    end

    // Randomized run against the model
    do_reset();
    btn_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (btn_left == 0) begin
        dif.btn_in = 1'($urandom_range(0, 1));
        btn_left   = $urandom_range(1, 12);
      end
      btn_left--;
      if ($urandom_range(0, 49) == 0) dif.wdt_en = ~dif.wdt_en;
      dif.wdt_kick = ($urandom_range(0, 11) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
